// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem handshake and the IF/ID register.
// A one-entry hold buffer absorbs a word that returns while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [3:0]  OpCode
);

  localparam logic [1:0] RESET = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic [31:0] hb_instr;
  logic [31:0] hb_pc;
  logic [31:0] pc_next;
  logic [31:0] tgt;

  assign pc_next = pc + 32'(PC_STEP);
  assign tgt     = {branch_target[31:2], 2'b00};

  assign imem_req  = (state == FETCH) || (state == DROP);
  assign imem_addr = (state == DROP) ? drop_addr : pc;
  assign OpCode    = if_valid ? if_instr[31:28] : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RESET;
      pc        <= RESET_PC;
      drop_addr <= 32'h0;
      hb_instr  <= 32'h0;
      hb_pc     <= 32'h0;
      if_valid  <= 1'b0;
      if_instr  <= 32'h0;
      if_pc     <= 32'h0;
    end else begin
      unique case (state)
        RESET: begin
          state <= FETCH;
        end
        FETCH: begin
          if (branch_taken) begin
            pc       <= tgt;
            if_valid <= 1'b0;
            if (!imem_ack) begin
              drop_addr <= pc;
              state     <= DROP;
            end
          end else if (flush) begin
            if_valid <= 1'b0;
          end else if (imem_ack) begin
            pc <= pc_next;
            if (!stall || !if_valid) begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
            end else begin
              hb_instr <= imem_rdata;
              hb_pc    <= pc;
              state    <= HOLD;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc       <= tgt;
            if_valid <= 1'b0;
            state    <= FETCH;
          end else if (flush) begin
            if_valid <= 1'b0;
            state    <= FETCH;
          end else if (!stall) begin
            if_instr <= hb_instr;
            if_pc    <= hb_pc;
            if_valid <= 1'b1;
            state    <= FETCH;
          end
        end
        DROP: begin
          // The late word belongs to the squashed path; only pc follows redirects.
          if_valid <= 1'b0;
          if (branch_taken) pc <= tgt;
          if (imem_ack) state <= FETCH;
        end
        default: state <= RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem handshake driven step by step.
// A second instance with RESET_PC at the top of memory checks PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [3:0]  OpCode;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [3:0]  w_op;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .OpCode(OpCode)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc),
    .OpCode(w_op)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_op", 32'(OpCode), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_wreq", 32'(w_req), 32'd0);

    imem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    chk("first_nvalid", 32'(if_valid), 32'd0);

    imem_ack = 1'b1; imem_rdata = 32'h8000_0000;
    tick();
    chk("i0_valid", 32'(if_valid), 32'd1);
    chk("i0_pc", if_pc, 32'h0);
    chk("i0_instr", if_instr, 32'h8000_0000);
    chk("i0_op", 32'(OpCode), 32'h8);
    chk("i1_addr", imem_addr, 32'h4);
    chk("wrap_addr1", w_addr, 32'h0);

    imem_ack = 1'b0;
    tick();
    chk("bubble0", 32'(if_valid), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h8000_0004;
    tick();
    chk("i1_pc", if_pc, 32'h4);
    chk("i1_instr", if_instr, 32'h8000_0004);
    imem_ack = 1'b0;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h8000_0008;
    tick();
    chk("i2_pc", if_pc, 32'h8);
    chk("i2_valid", 32'(if_valid), 32'd1);
    chk("i3_addr", imem_addr, 32'hC);

    stall = 1'b1; imem_ack = 1'b0;
    tick();
    chk("stall_pc", if_pc, 32'h8);
    chk("stall_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h8000_000C;
    tick();
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_pc", if_pc, 32'h8);
    chk("hold_instr", if_instr, 32'h8000_0008);
    imem_ack = 1'b0;
    tick();
    chk("hold2_req", 32'(imem_req), 32'd0);
    tick();
    chk("hold3_valid", 32'(if_valid), 32'd1);
    chk("hold3_pc", if_pc, 32'h8);
    stall = 1'b0;
    tick();
    chk("unhold_pc", if_pc, 32'hC);
    chk("unhold_instr", if_instr, 32'h8000_000C);
    chk("unhold_valid", 32'(if_valid), 32'd1);
    chk("unhold_req", 32'(imem_req), 32'd1);
    chk("unhold_addr", imem_addr, 32'h10);
    tick();
    chk("nodup", 32'(if_valid), 32'd0);

    branch_taken = 1'b1; branch_target = 32'h0000_0103;
    tick();
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr", imem_addr, 32'h10);
    chk("drop_valid", 32'(if_valid), 32'd0);
    branch_taken = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0000;
    tick();
    chk("late_discard", 32'(if_valid), 32'd0);
    chk("tgt_addr", imem_addr, 32'h100);
    imem_ack = 1'b0;
    tick();
    chk("tgt_req", 32'(imem_req), 32'd1);

    imem_ack = 1'b1; imem_rdata = 32'h8000_0100;
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    tick();
    chk("brack_valid", 32'(if_valid), 32'd0);
    chk("brack_addr", imem_addr, 32'h200);
    branch_taken = 1'b0;
    imem_rdata = 32'h8000_0200;
    tick();
    chk("b2_pc", if_pc, 32'h200);
    chk("b2_valid", 32'(if_valid), 32'd1);

    imem_ack = 1'b0; flush = 1'b1; stall = 1'b1;
    tick();
    chk("fs_valid", 32'(if_valid), 32'd0);
    chk("fs_op", 32'(OpCode), 32'd0);
    chk("fs_addr", imem_addr, 32'h204);
    stall = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h8000_0204;
    tick();
    chk("fack_valid", 32'(if_valid), 32'd0);
    chk("fack_addr", imem_addr, 32'h204);
    flush = 1'b0;
    tick();
    chk("refetch_pc", if_pc, 32'h204);
    chk("refetch_instr", if_instr, 32'h8000_0204);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
